// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: per-stage freeze vector from hazard requests and
// a multi-cycle unit, plus a registered one-cycle flush with redirect PC on exceptions.
module pipe_ctrl_gen #(
  parameter int              STAGES    = 6,
  parameter int              NREQ      = 2,
  parameter logic [NREQ*4-1:0] REQ_STAGE = {4'd3, 4'd2},
  parameter int              MC_STAGE  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              mc_start,
  input  logic [7:0]        mc_cycles,
  input  logic              excp_valid,
  input  logic [31:0]       excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic [31:0]       stall_cnt
);

  // state   | meaning
  // IDLE    | no multi-cycle op, no redirect pending
  // MC_BUSY | multi-cycle counter nonzero, front stages frozen
  // FLUSH   | one-cycle flush with redirect PC, stall suppressed
  typedef enum logic [1:0] {IDLE, MC_BUSY, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [STAGES-1:0] stall_raw;

  function automatic logic [STAGES-1:0] mask(input int k);
    logic [STAGES-1:0] m;
    for (int i = 0; i < STAGES; i++) m[i] = (i <= k);
    return m;
  endfunction

  assign mc_busy = (state_q == MC_BUSY);
  assign flush   = (state_q == FLUSH);
  assign new_pc  = flush ? pc_q : 32'd0;

  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NREQ; i++)
      if (stall_req[i]) stall_raw |= mask(int'(REQ_STAGE[i*4 +: 4]));
    if (mc_busy) stall_raw |= mask(MC_STAGE);
  end

  // Gated by resetn so requests cannot leak through while the block is held in reset.
  assign stall = (resetn && !flush) ? stall_raw : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (excp_valid) begin
      state_d = FLUSH;
      cnt_d   = 8'd0;
      pc_d    = excp_pc;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_start && (mc_cycles != 8'd0)) begin
            state_d = MC_BUSY;
            cnt_d   = mc_cycles;
          end
        end
        MC_BUSY: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = IDLE;
        end
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt <= 32'd0;
    else if ((stall != '0) && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 Parameter STAGES, default 6: number of pipeline stages and stall vector width; bit 0 is PC, bit STAGES-1 is WB.
REQ-002 Parameter NREQ, default 2: number of single-cycle stall requesters.
REQ-003 Parameter REQ_STAGE, default {4'd3,4'd2}: packed NREQ x 4-bit field giving the highest stage each requester freezes; requester 0 is in bits [3:0].
REQ-004 Parameter MC_STAGE, default 3: highest stage frozen while a multi-cycle operation is busy.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 stall_req  input  NREQ  combinational stall requests, e.g. load-use and EX hazard.
REQ-008 mc_start  input  1  one-cycle pulse that launches a multi-cycle operation (DIV/MUL).
REQ-009 mc_cycles  input  8  busy length in cycles, sampled when mc_start is high.
REQ-010 excp_valid  input  1  exception or ERET commit pulse.
REQ-011 excp_pc  input  32  redirect target, sampled with excp_valid.
REQ-012 stall  output  STAGES  per-stage freeze vector.
REQ-013 flush  output  1  registered one-cycle pipeline flush.
REQ-014 new_pc  output  32  redirect PC; valid only while flush=1, otherwise 0.
REQ-015 mc_busy  output  1  high while the multi-cycle counter is nonzero.
REQ-016 stall_cnt  output  32  count of cycles in which stall!=0; saturates at 32'hFFFF_FFFF.

Function
REQ-017 Stall mask: mask(k) = bits [k:0] set, all higher bits clear; for example, k=2 gives 6'b00_0111.
REQ-018 stall = OR of mask(REQ_STAGE[i]) over every asserted stall_req[i], ORed with mask(MC_STAGE) when mc_busy=1; the path is combinational from stall_req.
REQ-019 Three states: IDLE, MC_BUSY, FLUSH.
REQ-020 IDLE to MC_BUSY: mc_start=1 and mc_cycles!=0 loads the counter on the next edge; mc_cycles=0 is ignored.
REQ-021 MC_BUSY: the counter decrements once per cycle; when the counter reaches 0, the block returns to IDLE on the same edge and mc_busy falls.
REQ-022 mc_start is ignored while in MC_BUSY; the counter is not reloaded.
REQ-023 Exception capture: excp_valid=1 in any state latches excp_pc, clears the counter, and enters FLUSH on the next edge.
REQ-024 excp_valid takes priority over a simultaneous mc_start and over the counter decrement.
REQ-025 FLUSH lasts exactly one cycle: flush=1, new_pc=latched PC, stall forced to 0 regardless of stall_req, mc_busy=0.
REQ-026 FLUSH exit: the next state is IDLE, except that excp_valid=1 during FLUSH re-enters FLUSH with the new PC, giving back-to-back flush pulses.
REQ-027 mc_start during FLUSH is dropped.
REQ-028 stall_cnt increments on each edge where the stall output is nonzero; FLUSH cycles are not counted.
REQ-029 Flush latency: flush asserts exactly 1 cycle after excp_valid.
REQ-030 Stall latency: 0 cycles for stall_req; 1 cycle after mc_start for the multi-cycle stall.

Reset
REQ-031 resetn=0 asynchronously forces: state IDLE, counter 0, stall=0, flush=0, new_pc=0, mc_busy=0, stall_cnt=0.
REQ-032 A reset taken mid-MC_BUSY or mid-FLUSH aborts the operation with no residual pulse after release.
REQ-033 While resetn=0, stall=0 regardless of stall_req.
REQ-034 The first valid edge is the first rising clk edge after resetn rises.

Verification
REQ-035 Defaults; stall_req=2'b01 -> stall=6'b00_0111 in the same cycle; 2'b10 -> 6'b00_1111; 2'b11 -> 6'b00_1111; stall_cnt +1 per cycle.
REQ-036 mc_start with mc_cycles=4 -> mc_busy=1 and stall=6'b00_1111 for exactly 4 cycles starting the next cycle, then 0; mc_cycles=0 -> no stall.
REQ-037 excp_valid with excp_pc=32'hBFC0_0380 -> the next cycle has flush=1, new_pc=32'hBFC0_0380, stall=0 even with stall_req=2'b11; the following cycle has flush=0 and new_pc=0.
REQ-038 excp_valid during the 2nd cycle of a 5-cycle multi-cycle op -> one flush pulse, mc_busy drops with it, no further multi-cycle stall.
REQ-039 excp_valid on two consecutive cycles with PCs A then B -> flush high 2 cycles with new_pc A then B.
REQ-040 resetn asserted mid-MC_BUSY with counter 3 -> all outputs 0 immediately; after release, stall follows stall_req only; stall_cnt preloaded near 32'hFFFF_FFFF saturates at all-ones.
